// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Build option: FETCH_BURST_EN selects 4-word bursts; when it is undefined, fetches are single-word.
package fetch_pkg;

   localparam int unsigned XLEN = 32;
   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h8002_0000;

   localparam logic [1:0] ACC_1W = 2'b00;
   localparam logic [1:0] ACC_4W = 2'b01;

`ifdef FETCH_BURST_EN
   localparam int unsigned BEATS    = 4;
   localparam logic [1:0]  ACC_SIZE = ACC_4W;
`else
   localparam int unsigned BEATS    = 1;
   localparam logic [1:0]  ACC_SIZE = ACC_1W;
`endif

   typedef enum logic [1:0] {IDLE, REQ, RECV, DISCARD} fetch_state_t;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] insn;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Shift-register FIFO of fetch entries. Entry 0 is the head and drives the outputs straight from flops.
// Ports: clock, reset (sync, active-high), flush_i (drop everything), push_i/push_data_i (enqueue),
//        pop_i (dequeue if head valid), head_o/head_valid_o (registered head), count_o (occupancy).
module fetch_buffer
   import fetch_pkg::*;
#(
   parameter  int unsigned DEPTH = 4,
   localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             flush_i,
   input  logic             push_i,
   input  fetch_entry_t     push_data_i,
   input  logic             pop_i,
   output fetch_entry_t     head_o,
   output logic             head_valid_o,
   output logic [CNT_W-1:0] count_o
);

   fetch_entry_t     ent_q [DEPTH];
   fetch_entry_t     ent_d [DEPTH];
   logic [DEPTH-1:0] vld_q, vld_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] wr_idx;
   logic             do_pop;
   logic             do_push;

   assign do_pop = pop_i & vld_q[0];

   // Shift on pop, then write the new entry just behind the (post-pop) tail.
   always_comb begin
      ent_d   = ent_q;
      vld_d   = vld_q;
      wr_idx  = cnt_q - CNT_W'(do_pop);
      do_push = push_i && (wr_idx < CNT_W'(DEPTH));
      if (do_pop) begin
         for (int i = 0; i < DEPTH - 1; i++) begin
            ent_d[i] = ent_q[i+1];
            vld_d[i] = vld_q[i+1];
         end
         vld_d[DEPTH-1] = 1'b0;
      end
      if (do_push) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (CNT_W'(i) == wr_idx) begin
               ent_d[i] = push_data_i;
               vld_d[i] = 1'b1;
            end
         end
      end
      cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
      if (flush_i) begin
         vld_d = '0;
         cnt_d = '0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
         vld_q <= '0;
         cnt_q <= '0;
      end else begin
         ent_q <= ent_d;
         vld_q <= vld_d;
         cnt_q <= cnt_d;
      end
   end

   assign head_o       = ent_q[0];
   assign head_valid_o = vld_q[0];
   assign count_o      = cnt_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, issues read requests, buffers returned words for decode.
// Build option: FETCH_BURST_EN (4-word bursts); when it is undefined, fetches are single-word.
// Ports: clock, reset (sync, active-high), fetch_enable;
//        memory side: mem_req, mem_address, mem_access_size, mem_rw, mem_data_out, mem_data_valid;
//        decode side: insn, insn_pc, insn_valid, insn_ready; redirect_valid, redirect_pc.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
   parameter int unsigned     BUF_DEPTH = 4,
   parameter int unsigned     ADDR_W    = XLEN
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              fetch_enable,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_address,
   output logic [1:0]        mem_access_size,
   output logic              mem_rw,
   input  logic [ADDR_W-1:0] mem_data_out,
   input  logic              mem_data_valid,
   output logic [ADDR_W-1:0] insn,
   output logic [ADDR_W-1:0] insn_pc,
   output logic              insn_valid,
   input  logic              insn_ready,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc
);

   localparam int unsigned       CNT_W       = $clog2(BUF_DEPTH + 1);
   localparam int unsigned       BEAT_W      = $clog2(BEATS + 1);
   localparam logic [CNT_W-1:0]  FREE_LIMIT  = CNT_W'(BUF_DEPTH - BEATS);
   localparam logic [ADDR_W-1:0] BURST_BYTES = ADDR_W'(4 * BEATS);

   fetch_state_t      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] tag_q, tag_d;
   logic [BEAT_W-1:0] beat_q, beat_d;
   logic              mem_req_q, mem_req_d;
   logic [ADDR_W-1:0] mem_address_q, mem_address_d;
   logic [1:0]        size_q, size_d;

   logic              push;
   fetch_entry_t      push_entry;
   fetch_entry_t      head;
   logic [CNT_W-1:0]  buf_count;
   logic [ADDR_W-1:0] redir_pc;
   logic              last_beat;

   assign redir_pc  = redirect_pc & ~ADDR_W'(3);
   assign last_beat = (beat_q == BEAT_W'(BEATS - 1));

   // beat_q counts received beats in RECV and remaining beats to drop in DISCARD.
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      tag_d         = tag_q;
      beat_d        = beat_q;
      mem_req_d     = 1'b0;
      mem_address_d = mem_address_q;
      size_d        = size_q;
      push          = 1'b0;
      case (state_q)
         IDLE: begin
            if (!redirect_valid && fetch_enable && (buf_count <= FREE_LIMIT)) begin
               state_d       = REQ;
               mem_req_d     = 1'b1;
               mem_address_d = pc_q;
               size_d        = ACC_SIZE;
            end
         end
         REQ: begin
            tag_d = pc_q;
            if (redirect_valid) begin
               state_d = DISCARD;
               beat_d  = BEAT_W'(BEATS);
            end else begin
               state_d = RECV;
               beat_d  = '0;
            end
         end
         RECV: begin
            if (redirect_valid) begin
               if (mem_data_valid && last_beat) begin
                  state_d = IDLE;
               end else begin
                  state_d = DISCARD;
                  beat_d  = BEAT_W'(BEATS) - beat_q - BEAT_W'(mem_data_valid);
               end
            end else if (mem_data_valid) begin
               push   = 1'b1;
               tag_d  = tag_q + ADDR_W'(4);
               beat_d = beat_q + BEAT_W'(1);
               if (last_beat) begin
                  pc_d    = pc_q + BURST_BYTES;
                  state_d = IDLE;
               end
            end
         end
         DISCARD: begin
            if (mem_data_valid) begin
               beat_d = beat_q - BEAT_W'(1);
               if (beat_q == BEAT_W'(1)) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (redirect_valid) pc_d = redir_pc;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= IDLE;
         pc_q          <= RESET_PC;
         tag_q         <= '0;
         beat_q        <= '0;
         mem_req_q     <= 1'b0;
         mem_address_q <= '0;
         size_q        <= '0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         tag_q         <= tag_d;
         beat_q        <= beat_d;
         mem_req_q     <= mem_req_d;
         mem_address_q <= mem_address_d;
         size_q        <= size_d;
      end
   end

   assign push_entry = '{pc: tag_q, insn: mem_data_out};

   fetch_buffer #(
      .DEPTH(BUF_DEPTH)
   ) u_buf (
      .clock       (clock),
      .reset       (reset),
      .flush_i     (redirect_valid),
      .push_i      (push),
      .push_data_i (push_entry),
      .pop_i       (insn_ready),
      .head_o      (head),
      .head_valid_o(insn_valid),
      .count_o     (buf_count)
   );

   assign mem_req         = mem_req_q;
   assign mem_address     = mem_address_q;
   assign mem_access_size = size_q;
   assign mem_rw          = 1'b1;
   assign insn            = head.insn;
   assign insn_pc         = head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
module tb_fetch_unit;

`ifdef FETCH_BURST_EN
   localparam int unsigned NB       = 4;
   localparam logic [1:0]  EXP_SIZE = 2'b01;
`else
   localparam int unsigned NB       = 1;
   localparam logic [1:0]  EXP_SIZE = 2'b00;
`endif
   localparam int unsigned DEPTH  = 4;
   localparam logic [31:0] RST_PC = 32'h8002_0000;

   logic        clock = 1'b0;
   logic        reset, fetch_enable, mem_req, mem_rw, mem_data_valid;
   logic        insn_valid, insn_ready, redirect_valid;
   logic [31:0] mem_address, mem_data_out, insn, insn_pc, redirect_pc;
   logic [1:0]  mem_access_size;

   always #5 clock = ~clock;

   fetch_unit dut (
      .clock          (clock),
      .reset          (reset),
      .fetch_enable   (fetch_enable),
      .mem_req        (mem_req),
      .mem_address    (mem_address),
      .mem_access_size(mem_access_size),
      .mem_rw         (mem_rw),
      .mem_data_out   (mem_data_out),
      .mem_data_valid (mem_data_valid),
      .insn           (insn),
      .insn_pc        (insn_pc),
      .insn_valid     (insn_valid),
      .insn_ready     (insn_ready),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic wait_fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s actual=timeout required=event", name);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Memory contents: a fixed, address-dependent word.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'hC0DE_1234;
   endfunction

   // Memory model: BEATS words in order after the request cycle, random gaps.
   int unsigned pend = 0;
   logic [31:0] beat_addr = '0;
   initial begin
      mem_data_valid = 1'b0;
      mem_data_out   = '0;
      forever begin
         tick();
         mem_data_valid = 1'b0;
         if (pend != 0 && $urandom_range(0, 2) != 0) begin
            mem_data_valid = 1'b1;
            mem_data_out   = mem_word(beat_addr);
            beat_addr      = beat_addr + 32'd4;
            pend--;
         end
         if (mem_req === 1'b1) begin
            pend      = NB;
            beat_addr = mem_address;
         end
      end
   end

   // Reference model: decode sees consecutive words from the current fetch PC; a redirect restarts it.
   typedef struct {
      logic [31:0] pc;
      logic [31:0] w;
   } exp_t;

   exp_t        exp_q[$];
   bit          mon_en      = 1'b0;
   logic [31:0] seq_pc      = RST_PC;
   logic [31:0] req_exp     = RST_PC;
   bit          live        = 1'b0;
   int          outstanding = 0;
   bit          fe_prev     = 1'b1;
   int          pops        = 0;

   always @(negedge clock) begin : monitor
      exp_t e;
      if (mon_en) begin
         check("insn_valid", 32'(insn_valid), 32'(exp_q.size() != 0));
         if (insn_valid && insn_ready && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("insn_pc", insn_pc, e.pc);
            check("insn", insn, e.w);
            pops++;
         end
         if (mem_data_valid) begin
            outstanding--;
            if (live && !redirect_valid) begin
               exp_q.push_back('{seq_pc, mem_word(seq_pc)});
               seq_pc = seq_pc + 32'd4;
            end
         end
         if (mem_req) begin
            check("mem_address", mem_address, req_exp);
            check("mem_access_size", 32'(mem_access_size), 32'(EXP_SIZE));
            check("mem_rw", 32'(mem_rw), 32'd1);
            check("req_outstanding", 32'(outstanding), 32'd0);
            check("req_enable", 32'(fe_prev), 32'd1);
            check("req_space", 32'(exp_q.size() <= int'(DEPTH - NB)), 32'd1);
            req_exp     = req_exp + 32'(4 * NB);
            outstanding = NB;
            live        = 1'b1;
         end
         if (redirect_valid) begin
            exp_q.delete();
            seq_pc  = redirect_pc & 32'hFFFF_FFFC;
            req_exp = redirect_pc & 32'hFFFF_FFFC;
            live    = 1'b0;
         end
         fe_prev = fetch_enable;
      end
   end

   bit found;

   initial begin
      reset          = 1'b1;
      fetch_enable   = 1'b1;
      insn_ready     = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      check("rst_mem_req", 32'(mem_req), 32'd0);
      check("rst_mem_address", mem_address, 32'd0);
      check("rst_mem_access_size", 32'(mem_access_size), 32'd0);
      check("rst_insn", insn, 32'd0);
      check("rst_insn_pc", insn_pc, 32'd0);
      check("rst_insn_valid", 32'(insn_valid), 32'd0);
      tick();
      reset  = 1'b0;
      mon_en = 1'b1;

      // Straight-line fetch from the reset PC.
      insn_ready = 1'b1;
      repeat (30) tick();

      // Randomised enable, back-pressure and redirects.
      for (int i = 0; i < 1500; i++) begin
         fetch_enable   = ($urandom_range(0, 7) != 0);
         insn_ready     = ($urandom_range(0, 3) != 0);
         redirect_valid = ($urandom_range(0, 24) == 0);
         redirect_pc    = ($urandom_range(0, 3) == 0) ?
                          (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : 32'($urandom);
         tick();
      end
      redirect_valid = 1'b0;
      fetch_enable   = 1'b1;

      // Fill the buffer, then a single pop, then drain.
      insn_ready = 1'b0;
      repeat (40) tick();
      check("fill_count", 32'(exp_q.size()), 32'(DEPTH));
      check("fill_valid", 32'(insn_valid), 32'd1);
      insn_ready = 1'b1;
      tick();
      insn_ready = 1'b0;
      repeat (10) tick();
      insn_ready = 1'b1;
      repeat (30) tick();

      // Redirect to an unaligned target right after the first beat of a request.
      found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         @(negedge clock);
         if (mem_data_valid && pend == NB - 1) found = 1'b1;
      end
      if (!found) wait_fail("wait_first_beat");
      tick();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h8002_0103;
      tick();
      redirect_valid = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 50 && !found; i++) begin
         @(negedge clock);
         if (mem_req) found = 1'b1;
      end
      if (!found) wait_fail("wait_redirect_req");
      else check("redirect_req_addr", mem_address, 32'h8002_0100);
      repeat (30) tick();

      // Redirect in the same cycle as an accepted handshake.
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         tick();
         if (insn_valid) found = 1'b1;
      end
      if (!found) wait_fail("wait_insn_valid");
      else begin
         redirect_valid = 1'b1;
         redirect_pc    = 32'h8002_0200;
         tick();
         redirect_valid = 1'b0;
         check("post_redirect_valid", 32'(insn_valid), 32'd0);
      end
      repeat (20) tick();

      // PC wrap at the top of the address space.
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFFC;
      tick();
      redirect_valid = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 50 && !found; i++) begin
         @(negedge clock);
         if (mem_req) found = 1'b1;
      end
      if (!found) wait_fail("wait_wrap_req");
      else check("wrap_req_addr", mem_address, 32'hFFFF_FFFC);
      found = 1'b0;
      for (int i = 0; i < 50 && !found; i++) begin
         @(negedge clock);
         if (mem_req) found = 1'b1;
      end
      if (!found) wait_fail("wait_wrap_next_req");
      else check("wrap_next_addr", mem_address, 32'hFFFF_FFFC + 32'(4 * NB));

      // Stop fetching; in-flight work completes and drains.
      fetch_enable = 1'b0;
      repeat (60) tick();
      check("pops_min", 32'(pops >= 100), 32'd1);
      mon_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
